// File: rtl/mvm5_bias_stream.sv
`default_nettype none
// ============================================================================
// Module  : mvm5_bias_stream
// Brief   : Streaming y = A*x + b engine (NxN signed 8-bit operands), fed and
//           drained word-serially over valid/ready. Optional output clamping
//           is enabled with the MVM_SATURATE_EN macro (default: wrap).
// Rev     : 1.0 - initial release
// ============================================================================
module mvm5_bias_stream #(
    parameter int N     = 5,
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    input  logic             m_ready,
    input  logic [IN_W-1:0]  data_in,
    output logic             m_valid,
    output logic             s_ready,
    output logic [OUT_W-1:0] data_out
);

    localparam int c_WORDS  = N*N + 2*N;
    localparam int c_ACC_W  = OUT_W + 8;
    localparam int c_PROD_W = 2*IN_W;
    localparam int c_CNT_W  = $clog2(c_WORDS);
    localparam int c_ROW_W  = $clog2(N);
    localparam int c_STEP_W = $clog2(N + 2);

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_COMPUTE = 2'd1,
        S_OUTPUT  = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [c_CNT_W-1:0]         cnt_q, cnt_d;
    logic [c_ROW_W-1:0]         row_q, row_d;
    logic [c_STEP_W-1:0]        step_q, step_d;
    logic signed [c_ACC_W-1:0]  acc_q, acc_d;
    logic [OUT_W-1:0]           data_out_q, data_out_d;
    logic                       m_valid_q, m_valid_d;
    logic                       s_ready_q, s_ready_d;

    logic [IN_W-1:0]            mem_q [c_WORDS];

    logic                       w_in_fire;
    logic                       w_out_fire;
    logic [c_CNT_W-1:0]         w_a_idx, w_x_idx, w_b_idx;
    logic [IN_W-1:0]            w_a, w_x, w_b;
    logic signed [c_PROD_W-1:0] w_prod;
    logic [c_ACC_W-1:0]         w_prod_ext, w_b_ext;
    logic [OUT_W-1:0]           w_res;

    assign w_in_fire  = s_valid && s_ready_q;
    assign w_out_fire = m_valid_q && m_ready;

    // Operand layout in mem_q: A row-major, then x, then b.
    assign w_a_idx = c_CNT_W'(int'(row_q) * N + int'(step_q) - 1);
    assign w_x_idx = c_CNT_W'(N * N + int'(step_q) - 1);
    assign w_b_idx = c_CNT_W'(N * N + N + int'(row_q));

    assign w_a        = mem_q[w_a_idx];
    assign w_x        = mem_q[w_x_idx];
    assign w_b        = mem_q[w_b_idx];
    assign w_prod     = $signed(w_a) * $signed(w_x);
    assign w_prod_ext = {{(c_ACC_W-c_PROD_W){w_prod[c_PROD_W-1]}}, w_prod};
    assign w_b_ext    = {{(c_ACC_W-IN_W){w_b[IN_W-1]}}, w_b};

`ifdef MVM_SATURATE_EN
    localparam logic signed [c_ACC_W-1:0] c_SAT_MAX = c_ACC_W'((1 <<< (OUT_W-1)) - 1);
    localparam logic signed [c_ACC_W-1:0] c_SAT_MIN = c_ACC_W'(-(1 <<< (OUT_W-1)));

    always_comb begin
        w_res = acc_q[OUT_W-1:0];
        if (acc_q > c_SAT_MAX) begin
            w_res = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (acc_q < c_SAT_MIN) begin
            w_res = {1'b1, {(OUT_W-1){1'b0}}};
        end
    end
`else
    assign w_res = acc_q[OUT_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            mem_q[cnt_q] <= data_in;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        row_d      = row_q;
        step_d     = step_q;
        acc_d      = acc_q;
        data_out_d = data_out_q;
        m_valid_d  = m_valid_q;
        s_ready_d  = s_ready_q;
        case (state_q)
            S_LOAD: begin
                s_ready_d = 1'b1;
                m_valid_d = 1'b0;
                if (w_in_fire) begin
                    if (cnt_q == c_CNT_W'(c_WORDS - 1)) begin
                        state_d   = S_COMPUTE;
                        cnt_d     = '0;
                        row_d     = '0;
                        step_d    = '0;
                        s_ready_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_COMPUTE: begin
                // step 0 seeds with b[r], steps 1..N accumulate, step N+1 publishes
                if (step_q == '0) begin
                    acc_d  = $signed(w_b_ext);
                    step_d = step_q + 1'b1;
                end else if (step_q <= c_STEP_W'(N)) begin
                    acc_d  = acc_q + $signed(w_prod_ext);
                    step_d = step_q + 1'b1;
                end else begin
                    data_out_d = w_res;
                    m_valid_d  = 1'b1;
                    step_d     = '0;
                    state_d    = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (w_out_fire) begin
                    m_valid_d = 1'b0;
                    if (row_q == c_ROW_W'(N - 1)) begin
                        row_d     = '0;
                        s_ready_d = 1'b1;
                        state_d   = S_LOAD;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = S_COMPUTE;
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_LOAD;
            cnt_q      <= '0;
            row_q      <= '0;
            step_q     <= '0;
            acc_q      <= '0;
            data_out_q <= '0;
            m_valid_q  <= 1'b0;
            s_ready_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            step_q     <= step_d;
            acc_q      <= acc_d;
            data_out_q <= data_out_d;
            m_valid_q  <= m_valid_d;
            s_ready_q  <= s_ready_d;
        end
    end

    assign m_valid  = m_valid_q;
    assign s_ready  = s_ready_q;
    assign data_out = data_out_q;

endmodule
`default_nettype wire

// File: tb/tb_mvm5_bias_stream.sv
`default_nettype none
// ============================================================================
// Module  : tb_mvm5_bias_stream
// Brief   : Directed, table-driven bench for mvm5_bias_stream.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_mvm5_bias_stream;

    localparam int N = 5;

    logic        clk;
    logic        reset;
    logic        s_valid;
    logic        m_ready;
    logic [7:0]  data_in;
    logic        m_valid;
    logic        s_ready;
    logic [15:0] data_out;

    mvm5_bias_stream #(.N(N), .IN_W(8), .OUT_W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .s_valid  (s_valid),
        .m_ready  (m_ready),
        .data_in  (data_in),
        .m_valid  (m_valid),
        .s_ready  (s_ready),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a [25];
        logic [7:0] x [5];
        logic [7:0] b [5];
        int         y [5];
    } vec_t;

    vec_t vecs [4];
    int   n_cmp = 0;
    int   n_err = 0;
    int   both_err = 0;
    int   load_mv_err = 0;

    always @(negedge clk) begin
        if (s_ready && m_valid) both_err++;
    end

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        #1;
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_s_ready", int'(s_ready), 0);
        check("rst_data_out", int'(data_out), 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_s_ready_pre_edge", int'(s_ready), 0);
        @(posedge clk);
        #1;
        check("rst_s_ready_first_edge", int'(s_ready), 1);
    endtask

    task automatic send_word(input logic [7:0] w);
        int g;
        int budget;
        g = $urandom_range(0, 2);
        s_valid = 1'b0;
        data_in = 8'($urandom);
        repeat (g) begin
            @(posedge clk);
            #1;
            if (m_valid) load_mv_err++;
        end
        s_valid = 1'b1;
        data_in = w;
        budget  = 0;
        while (!s_ready && budget < 100) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (!s_ready) begin
            check("send_timeout", 1, 0);
        end else begin
            if (m_valid) load_mv_err++;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        data_in = 8'($urandom);
    endtask

    task automatic recv_word(input int exp, input int stall);
        int cyc;
        int bad;
        int g;
        cyc = 0;
        m_ready = 1'b0;
        while (!m_valid && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!m_valid) begin
            check("recv_timeout", 1, 0);
            return;
        end
        check("latency", cyc, N + 2);
        if (stall > 0) begin
            bad = 0;
            repeat (stall) begin
                @(posedge clk);
                #1;
                if (!m_valid || s_ready || $signed(data_out) != 16'(exp)) bad++;
            end
            check("stall_hold", bad, 0);
        end
        g = $urandom_range(0, 2);
        repeat (g) begin
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        check("y_value", int'($signed(data_out)), exp);
        @(posedge clk);
        #1;
        m_ready = 1'b0;
    endtask

    task automatic send_words(input int idx, input int count);
        for (int w = 0; w < count; w++) begin
            if (w < 25)      send_word(vecs[idx].a[w]);
            else if (w < 30) send_word(vecs[idx].x[w-25]);
            else             send_word(vecs[idx].b[w-30]);
        end
    endtask

    task automatic run_problem(input int idx, input int stall);
        load_mv_err = 0;
        send_words(idx, 35);
        check("m_valid_during_load", load_mv_err, 0);
        for (int r = 0; r < N; r++) begin
            recv_word(vecs[idx].y[r], (r == 0) ? stall : 0);
        end
        check("s_ready_after_last_out", int'(s_ready), 1);
        check("m_valid_after_last_out", int'(m_valid), 0);
    endtask

    initial begin
        // basic: row r of A is all r+1
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) vecs[0].a[r*5+c] = 8'(r + 1);
            vecs[0].x[r] = 8'(r + 1);
            vecs[0].b[r] = 8'd1;
        end
        vecs[0].y = '{16, 31, 46, 61, 76};
        // identity
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) vecs[1].a[r*5+c] = (r == c) ? 8'd1 : 8'd0;
            vecs[1].b[r] = 8'd0;
        end
        vecs[1].x = '{8'd10, 8'hEC, 8'd30, 8'hD8, 8'd50};
        vecs[1].y = '{10, -20, 30, -40, 50};
        // positive and negative overflow
        for (int i = 0; i < 25; i++) begin
            vecs[2].a[i] = 8'd127;
            vecs[3].a[i] = 8'h80;
        end
        for (int i = 0; i < 5; i++) begin
            vecs[2].x[i] = 8'd127;
            vecs[2].b[i] = 8'd127;
            vecs[3].x[i] = 8'd127;
            vecs[3].b[i] = 8'd0;
`ifdef MVM_SATURATE_EN
            vecs[2].y[i] = 32767;
            vecs[3].y[i] = -32768;
`else
            vecs[2].y[i] = 15236;
            vecs[3].y[i] = -15744;
`endif
        end

        s_valid = 1'b0;
        m_ready = 1'b0;
        data_in = 8'd0;
        reset   = 1'b0;
        do_reset();

        for (int i = 0; i < 4; i++) begin
            run_problem(i, (i == 0) ? 20 : 0);
        end

        // abort after 20 of 35 words, then a clean basic problem
        send_words(1, 20);
        do_reset();
        run_problem(0, 0);

        check("s_ready_and_m_valid_overlap", both_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/mvm5_bias_stream.md
Name: mvm5_bias_stream

Overview:
- Streaming matrix-vector multiply-accumulate engine: y = A·x + b, where A is N×N, x and b are length-N vectors, all 8-bit signed.
- Operands arrive word-serially on a valid/ready input stream. The N results leave word-serially on a valid/ready output stream.
- Sits between a producer and a consumer that both use the standard valid/ready handshake. Handles one problem at a time, then accepts the next.

Parameters:
- N, 5, matrix dimension; vector length; number of outputs per problem.
- IN_W, 8, signed input word width.
- OUT_W, 16, signed output word width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- s_valid  input  1  input word valid.
- m_ready  input  1  consumer ready for an output word.
- data_in  input  IN_W  signed input word.
- m_valid  output  1  data_out valid.
- s_ready  output  1  block can accept an input word.
- data_out  output  OUT_W  signed result word.

Behaviour:
- Single clock domain. The only asynchronous element is reset (active-low).
- While reset=0: state=LOAD, all counters=0, m_valid=0, s_ready=0, data_out=0.
- The first clk edge after reset deasserts sets s_ready=1.
- Handshakes:
  - An input word transfers on a rising edge with s_valid && s_ready.
  - An output word transfers on a rising edge with m_valid && m_ready.
  - data_in is ignored, and may be X, when no transfer occurs.
- Input order per problem (N*N + 2N = 35 words):
  - Words 0..N*N-1: A, row-major (A[0][0], A[0][1], …).
  - Next N words: x[0..N-1].
  - Last N words: b[0..N-1].
- State machine:
  - LOAD: s_ready=1, m_valid=0. Each accepted word is written to its register slot. After the 35th transfer, go to COMPUTE; s_ready drops the following cycle.
  - COMPUTE (row r): the accumulator is initialised to b[r], then one MAC per cycle adds A[r][j]*x[j] for j=0..N-1. That is N+1 cycles per row, then go to OUTPUT.
  - OUTPUT: data_out holds y[r] stable with m_valid=1 until the transfer. Then, if r<N-1: r++ and go to COMPUTE. Otherwise go to LOAD with s_ready=1 the next cycle.
- Latency:
  - First m_valid rises N+2 cycles after the last input transfer.
  - Each subsequent m_valid rises N+2 cycles after the previous output transfer.
- Back-pressure:
  - m_ready low holds OUTPUT indefinitely.
  - s_valid low stalls LOAD indefinitely.
  - No words are lost or duplicated.
- s_ready and m_valid are never both 1.
- Arithmetic:
  - Products are 16-bit signed (8x8).
  - The accumulator is OUT_W+8 bits signed.
  - Output conversion to OUT_W follows the optional feature.
- Stored A/x/b are overwritten only by the next problem's LOAD.
- Reset mid-operation (any state): abort immediately, discard partial results, return to the reset values above.

Optional Feature:
- Macro: MVM_SATURATE_EN.
- Defined: the accumulator result is clamped to [-32768, 32767] before driving data_out.
- Undefined: data_out = low OUT_W bits of the accumulator (two's-complement wrap).

Test Plan:
- Basic: A rows all 1, all 2, all 3, all 4, all 5 respectively; x=1,2,3,4,5; b=1,1,1,1,1; with random s_valid and m_ready gaps -> y=16,31,46,61,76 in order. m_valid must stay 0 before the 35th input.
- Stall/hold: m_ready held 0 for 20 cycles during OUTPUT -> data_out stays 16 and m_valid stays 1 throughout; s_ready stays 0.
- Back-to-back problems: after the basic problem, load A=identity, x=10,-20,30,-40,50, b=0 -> y=10,-20,30,-40,50. s_ready must reassert exactly one cycle after the 5th output transfer.
- Overflow: A all 127, x all 127, b all 127 -> y=15236 each without MVM_SATURATE_EN, 32767 each with it.
- Negative overflow: A all -128, x all 127, b all 0 -> y=-15744 each (wrap), -32768 each (saturate).
- Reset mid-problem: drive reset=0 after 20 inputs, release, then load the basic problem -> outputs 16,31,46,61,76, with m_valid=0 and s_ready=0 during reset.
